// File: rtl/zimo_scan_serializer.sv
// Streams one 16x16 glyph as a serial pixel raster, with each pixel repeated SCALE_X times and each row SCALE_Y times.
// Define ZIMO_SHADOW_BUFFER_EN to add a one-deep shadow glyph, so that frames can follow each other with no gap.
module zimo_scan_serializer #(
  parameter int SCALE_X = 2,
  parameter int SCALE_Y = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [255:0] glyph,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_data,
  output logic         pix_eol,
  output logic         pix_eof,
  output logic         busy
);

  localparam logic [2:0] XS_MAX = 3'(SCALE_X - 1);
  localparam logic [2:0] YS_MAX = 3'(SCALE_Y - 1);

  typedef enum logic {IDLE, SCAN} stateT;

  stateT        stateReg, stateNext;
  logic [255:0] activeReg, activeNext;
  logic [2:0]   xsReg, xsNext, ysReg, ysNext;
  logic [3:0]   colReg, colNext, rowReg, rowNext;
  logic         lastX, lastY, lineEnd, frameEnd, beatFire;
  logic [15:0]  rowBits [16];

`ifdef ZIMO_SHADOW_BUFFER_EN
  logic [255:0] shadowReg, shadowNext;
  logic         shadowFullReg, shadowFullNext;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rows
      assign rowBits[gi] = activeReg[16*gi +: 16];
    end
  endgenerate

  // All stream outputs come from registered state only.
  assign pix_valid = (stateReg == SCAN);
  assign busy      = (stateReg == SCAN);
  assign lastX     = (xsReg == XS_MAX);
  assign lastY     = (ysReg == YS_MAX);
  assign lineEnd   = pix_valid && (colReg == 4'd15) && lastX;
  assign frameEnd  = lineEnd && (rowReg == 4'd15) && lastY;
  assign pix_eol   = lineEnd;
  assign pix_eof   = frameEnd;
  assign pix_data  = pix_valid & rowBits[rowReg][colReg];
  assign beatFire  = pix_valid & pix_ready;

  // Raster counters: xs -> col -> ys -> row. A wrap of all four returns them to zero at frame end.
  always_comb begin
    xsNext  = xsReg;
    colNext = colReg;
    ysNext  = ysReg;
    rowNext = rowReg;
    if (stateReg == IDLE) begin
      xsNext  = '0;
      colNext = '0;
      ysNext  = '0;
      rowNext = '0;
    end else if (beatFire) begin
      if (!lastX) begin
        xsNext = xsReg + 3'd1;
      end else begin
        xsNext = '0;
        if (colReg != 4'd15) begin
          colNext = colReg + 4'd1;
        end else begin
          colNext = '0;
          if (!lastY) begin
            ysNext = ysReg + 3'd1;
          end else begin
            ysNext  = '0;
            rowNext = rowReg + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    stateNext  = stateReg;
    activeNext = activeReg;
    load_ready = 1'b0;
`ifdef ZIMO_SHADOW_BUFFER_EN
    shadowNext     = shadowReg;
    shadowFullNext = shadowFullReg;
`endif
    case (stateReg)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          activeNext = glyph;
          stateNext  = SCAN;
        end
      end
      SCAN: begin
`ifdef ZIMO_SHADOW_BUFFER_EN
        load_ready = !shadowFullReg;
        if (beatFire && frameEnd) begin
          // The next glyph comes from the shadow, or straight from the input, so that no bubble appears.
          if (shadowFullReg) begin
            activeNext     = shadowReg;
            shadowFullNext = 1'b0;
          end else if (load_valid) begin
            activeNext = glyph;
          end else begin
            stateNext = IDLE;
          end
        end else if (load_valid && !shadowFullReg) begin
          shadowNext     = glyph;
          shadowFullNext = 1'b1;
        end
`else
        if (beatFire && frameEnd) begin
          stateNext = IDLE;
        end
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      activeReg <= '0;
      xsReg     <= '0;
      colReg    <= '0;
      ysReg     <= '0;
      rowReg    <= '0;
    end else begin
      stateReg  <= stateNext;
      activeReg <= activeNext;
      xsReg     <= xsNext;
      colReg    <= colNext;
      ysReg     <= ysNext;
      rowReg    <= rowNext;
    end
  end

`ifdef ZIMO_SHADOW_BUFFER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadowReg     <= '0;
      shadowFullReg <= 1'b0;
    end else begin
      shadowReg     <= shadowNext;
      shadowFullReg <= shadowFullNext;
    end
  end
`endif

endmodule

// File: tb/tb_zimo_scan_serializer.sv
// Scoreboard bench for zimo_scan_serializer: a default 2x2 instance and a 1x1 corner instance.
`timescale 1ns/1ps
module tb_zimo_scan_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         loadValid, loadReady, pixValid, pixReady, pixData, pixEol, pixEof, busy;
  logic [255:0] glyph;
  logic         sLoadValid, sLoadReady, sPixValid, sPixReady, sPixData, sPixEol, sPixEof, sBusy;
  logic [255:0] sGlyph;

  zimo_scan_serializer #(.SCALE_X(2), .SCALE_Y(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(loadValid), .load_ready(loadReady), .glyph(glyph),
    .pix_valid(pixValid), .pix_ready(pixReady), .pix_data(pixData), .pix_eol(pixEol),
    .pix_eof(pixEof), .busy(busy)
  );

  zimo_scan_serializer #(.SCALE_X(1), .SCALE_Y(1)) dutS (
    .clk(clk), .rst_n(rst_n), .load_valid(sLoadValid), .load_ready(sLoadReady), .glyph(sGlyph),
    .pix_valid(sPixValid), .pix_ready(sPixReady), .pix_data(sPixData), .pix_eol(sPixEol),
    .pix_eof(sPixEof), .busy(sBusy)
  );

  typedef struct packed {logic d; logic eol; logic eof;} beatT;
  beatT q[$];
  beatT qS[$];

  int checks = 0, failures = 0;
  int beatCnt = 0, frames = 0, lastFrameBeats = 0, eofIdx = -1;
  int onesPos[$];
  int sBeatCnt = 0, sFrames = 0, sLastFrameBeats = 0, sEofIdx = -1, sEolCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference raster: row, y-copy, column, x-copy.
  task automatic pushFrame(input logic [255:0] g, input int sx, input int sy, input bit toS);
    beatT b;
    for (int r = 0; r < 16; r++)
      for (int yy = 0; yy < sy; yy++)
        for (int c = 0; c < 16; c++)
          for (int xx = 0; xx < sx; xx++) begin
            b.d   = g[16*r + c];
            b.eol = (c == 15) && (xx == sx - 1);
            b.eof = b.eol && (r == 15) && (yy == sy - 1);
            if (toS) qS.push_back(b);
            else     q.push_back(b);
          end
  endtask

  initial begin : monA
    beatT e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beatCnt = 0;
      end else if (pixValid && pixReady) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat idx=%0d actual=beat required=none", beatCnt);
        end else begin
          e = q.pop_front();
          check($sformatf("data@%0d", beatCnt), pixData, e.d);
          check($sformatf("eol@%0d", beatCnt), pixEol, e.eol);
          check($sformatf("eof@%0d", beatCnt), pixEof, e.eof);
        end
        if (pixData === 1'b1) onesPos.push_back(beatCnt);
        if (pixEof) begin
          eofIdx = beatCnt;
          lastFrameBeats = beatCnt + 1;
          frames++;
          beatCnt = 0;
        end else begin
          beatCnt++;
        end
      end
    end
  end

  initial begin : monS
    beatT e;
    forever begin
      @(negedge clk);
      if (rst_n && sPixValid && sPixReady) begin
        if (qS.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL s_extra_beat idx=%0d actual=beat required=none", sBeatCnt);
        end else begin
          e = qS.pop_front();
          check($sformatf("s_data@%0d", sBeatCnt), sPixData, e.d);
          check($sformatf("s_eol@%0d", sBeatCnt), sPixEol, e.eol);
          check($sformatf("s_eof@%0d", sBeatCnt), sPixEof, e.eof);
        end
        if (sPixEol) sEolCnt++;
        if (sPixEof) begin
          sEofIdx = sBeatCnt;
          sLastFrameBeats = sBeatCnt + 1;
          sFrames++;
          sBeatCnt = 0;
        end else begin
          sBeatCnt++;
        end
      end
    end
  end

  task automatic loadGlyph(input logic [255:0] g);
    int t = 0;
    loadValid = 1'b1;
    glyph = g;
    @(negedge clk);
    while (!loadReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("load_accept", loadReady, 1);
    pushFrame(g, 2, 2, 1'b0);
    @(posedge clk); #1;
    loadValid = 1'b0;
    check("first_valid", pixValid, 1);
    check("first_pixel", pixData, g[0]);
    check("busy_scan", busy, 1);
  endtask

  task automatic waitBeat(input int n);
    int t = 0;
    while (beatCnt != n && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_beat", beatCnt, n);
  endtask

  task automatic waitFrames(input int target, output int cycles);
    cycles = 0;
    while (frames < target && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("frame_done", frames, target);
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_load_ready"}, loadReady, 1);
    check({tag, "_pix_valid"}, pixValid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_eof"}, pixEof, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    int ft;
    logic [255:0] pat;
    rst_n = 1'b0;
    loadValid = 1'b0;
    glyph = '0;
    pixReady = 1'b1;
    sLoadValid = 1'b0;
    sGlyph = '0;
    sPixReady = 1'b1;
    #2;
    check("rst_valid", pixValid, 0);
    check("rst_busy", busy, 0);
    check("rst_eol", pixEol, 0);
    check("rst_eof", pixEof, 0);
    check("rst_s_valid", sPixValid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkIdle("post_rst");
    check("post_rst_s_ready", sLoadReady, 1);

    // 1x1 corner, all ones: 256 beats, eol every 16th beat
    sGlyph = '1;
    sLoadValid = 1'b1;
    @(negedge clk);
    check("s_accept", sLoadReady, 1);
    pushFrame(sGlyph, 1, 1, 1'b1);
    @(posedge clk); #1;
    sLoadValid = 1'b0;
    check("s_first_valid", sPixValid, 1);
    check("s_busy", sBusy, 1);
    cyc = 0;
    while (sFrames < 1 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("s_frame_done", sFrames, 1);
    check("s_beats", sLastFrameBeats, 256);
    check("s_eol_count", sEolCnt, 16);
    check("s_eof_idx", sEofIdx, 255);
    check("s_cycles", cyc, 256);
    check("s_idle_ready", sLoadReady, 1);

    // single pixel at defaults
    onesPos.delete();
    loadGlyph(256'h1);
    waitFrames(1, cyc);
    check("t1_cycles", cyc, 1024);
    check("t1_beats", lastFrameBeats, 1024);
    check("t1_eof_idx", eofIdx, 1023);
    check("t1_ones", onesPos.size(), 4);
    if (onesPos.size() == 4) begin
      check("t1_one0", onesPos[0], 0);
      check("t1_one1", onesPos[1], 1);
      check("t1_one2", onesPos[2], 32);
      check("t1_one3", onesPos[3], 33);
    end
    checkIdle("t1_idle");

    // stall at beat 66 on pixel (1,1)
    onesPos.delete();
    loadGlyph(256'h1 << 17);
    waitBeat(66);
    pixReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", pixData, 1);
      check("stall_valid", pixValid, 1);
      check("stall_eol", pixEol, 0);
      check("stall_beat", beatCnt, 66);
    end
    @(posedge clk); #1;
    pixReady = 1'b1;
    waitFrames(2, cyc);
    check("t2_beats", lastFrameBeats, 1024);
    check("t2_ones", onesPos.size(), 4);
    if (onesPos.size() == 4) begin
      check("t2_one0", onesPos[0], 66);
      check("t2_one1", onesPos[1], 67);
      check("t2_one2", onesPos[2], 98);
      check("t2_one3", onesPos[3], 99);
    end
    checkIdle("t2_idle");

`ifndef ZIMO_SHADOW_BUFFER_EN
    // a load offered mid-scan must be ignored
    pat = {16{16'hA5C3}};
    loadGlyph(pat);
    waitBeat(100);
    loadValid = 1'b1;
    glyph = ~pat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ign_ready", loadReady, 0);
    end
    @(posedge clk); #1;
    loadValid = 1'b0;
    waitFrames(3, cyc);
    check("ign_beats", lastFrameBeats, 1024);
    checkIdle("ign_idle");
`else
    // shadow: A all ones, B zeros loaded at beat 10, back to back
    loadGlyph('1);
    waitBeat(10);
    loadValid = 1'b1;
    glyph = '0;
    @(negedge clk);
    check("sh_ready_empty", loadReady, 1);
    pushFrame('0, 2, 2, 1'b0);
    @(posedge clk); #1;
    loadValid = 1'b0;
    ft = frames + 1;
    cyc = 0;
    while (frames < ft && cyc < 2000) begin
      check("sh_ready_full", loadReady, 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("sh_frame", frames, ft);
    check("sh_a_beats", lastFrameBeats, 1024);
    check("sh_valid_cont", pixValid, 1);
    check("sh_b_pixel", pixData, 0);
    check("sh_ready_after", loadReady, 1);
    waitFrames(ft + 1, cyc);
    check("sh_b_cycles", cyc, 1024);
    checkIdle("sh_idle");
`endif

    // mid-scan reset aborts the frame; a new glyph restarts from pixel (0,0)
    pat = 256'h1 | (256'h1 << 255);
    loadGlyph(pat);
    waitBeat(500);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", pixValid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_eof", pixEof, 0);
    q.delete();
    onesPos.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkIdle("mid_rst_idle");
    ft = frames + 1;
    loadGlyph(pat);
    waitFrames(ft, cyc);
    check("mid_cycles", cyc, 1024);
    check("mid_beats", lastFrameBeats, 1024);
    check("mid_ones", onesPos.size(), 8);
    if (onesPos.size() == 8) begin
      check("mid_first_one", onesPos[0], 0);
      check("mid_last_one", onesPos[7], 1023);
    end
    checkIdle("mid_idle");

    check("q_drained", q.size(), 0);
    check("qs_drained", qS.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/zimo_scan_serializer.md
Name: zimo_scan_serializer

Overview:
- Reader-side counterpart to the glyph amplification path.
- Accepts one 16x16 glyph bitmap (256 bits) per handshake and streams it out as a serial pixel stream.
- Each source pixel is replicated SCALE_X times horizontally; each glyph row is replicated SCALE_Y times vertically.
- Sits between the glyph ROM lookup and the VGA pixel compositor; the compositor back-pressures the stream.

Parameters:
- SCALE_X, 2, horizontal replication per source pixel; legal range 1..8.
- SCALE_Y, 2, vertical replication per source row; legal range 1..8.

Ports:
- clk, input, 1, single system clock; all logic rising-edge.
- rst_n, input, 1, reset; asynchronous assert, active-low.
- load_valid, input, 1, glyph word offered.
- load_ready, output, 1, block can accept a glyph this cycle.
- glyph, input, 256, bitmap; pixel(row r, col c) = glyph[16*r + c], r,c in 0..15.
- pix_valid, output, 1, pix_data is valid.
- pix_ready, input, 1, downstream accepts the beat.
- pix_data, output, 1, current pixel (1 = foreground).
- pix_eol, output, 1, high on the last beat of each output line (col 15, last x-copy).
- pix_eof, output, 1, high on the final beat of the glyph (pix_eol and row 15, last y-copy).
- busy, output, 1, high while in SCAN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; active buffer=0; all counters=0.
  - pix_valid=0, pix_eol=0, pix_eof=0, busy=0.
  - load_ready=1 once rst_n is high.
  - Assertion mid-scan aborts immediately: pix_valid drops in the same instant and the glyph is discarded.
- States: IDLE, SCAN.
- IDLE:
  - load_ready=1; pix_valid=0.
  - load_valid&load_ready: latch glyph into the active buffer, clear counters, go to SCAN next cycle.
- SCAN:
  - pix_valid=1, busy=1.
  - pix_data = active[16*row + col], a combinational mux of registered state only (no input-to-output path).
- Counters xs(3b), col(4b), ys(3b), row(4b) advance only on pix_valid&pix_ready:
  - xs wraps at SCALE_X-1 and carries into col.
  - col wraps at 15 and carries into ys.
  - ys wraps at SCALE_Y-1 and carries into row.
  - row wraps at 15, which ends the frame.
- Stall hold: with pix_valid=1 and pix_ready=0, pix_data, pix_eol, pix_eof and the counters hold unchanged.
- Frame length: 256*SCALE_X*SCALE_Y beats (1024 at defaults).
- Line length: 16*SCALE_X beats.
- Frame end: handshake with pix_eof=1 returns to IDLE next cycle, with counters cleared (unless the shadow feature supplies the next glyph).
- Latency: load accepted at cycle N gives pix_valid=1 with pixel(0,0) at cycle N+1. With pix_ready held at 1 the stream carries one beat per cycle.
- Base build: load_ready=0 throughout SCAN; load_valid is ignored there and the glyph input is not sampled.
- SCALE_X=1 and/or SCALE_Y=1: the corresponding counter is constant 0 and carries every beat.

Optional Feature:
- Macro: ZIMO_SHADOW_BUFFER_EN.
- Defined: adds a 256-bit shadow register plus a shadow_full flag.
  - During SCAN, load_ready = !shadow_full; an accepted load fills the shadow.
  - On the pix_eof handshake with shadow_full=1: shadow moves to active, shadow_full clears, counters clear, state stays SCAN. Pixel(0,0) of the new glyph appears next cycle with no bubble.
  - If a load is accepted in the same cycle as the pix_eof handshake while shadow is empty, the glyph goes directly to active with the same zero-bubble result.
  - Reset clears shadow_full.
- Undefined: no shadow storage; behaviour exactly as in Behaviour, with a minimum one-cycle IDLE gap between glyphs.

Test Plan:
- Single pixel, defaults: glyph=1 (only bit 0), pix_ready=1 → 1024 beats; pix_data=1 only on beats 0,1,32,33. pix_eol on beats 31,63,…,1023; pix_eof only on beat 1023; back to IDLE (load_ready=1) at cycle 1025.
- Stall: glyph bit 17 set (row1,col1); drop pix_ready for 5 cycles at beat 66 → pix_data=1 held stable across the stall; counters frozen; total handshaken beats still 1024.
- Ignored load (base build): assert load_valid with a new glyph at beat 100 → load_ready=0; stream output bit-identical to an uninterrupted run.
- Mid-scan reset: rst_n=0 at beat 500 → pix_valid=0 immediately; after release load_ready=1; a new glyph starts from pixel(0,0).
- Scale corners: SCALE_X=1, SCALE_Y=1, glyph=all-ones → 256 beats all 1; pix_eol every 16th beat; pix_eof on beat 255.
- ZIMO_SHADOW_BUFFER_EN: glyph A=all-ones, glyph B=0 loaded at beat 10 → beat 1023 =1 (A), next cycle beat 0 of B =0 with pix_valid continuous; load_ready=0 from beat 11 until the eof handshake.
